// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// mvm_pkg : FSM state type and sizing helpers shared by mvm_job_arbiter
// Rev 1.0
// ============================================================================
package mvm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_FEED  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    // Engine presents y[0] this many cycles after its done pulse
    localparam int ENGINE_LATENCY = 1;

    function automatic int job_words(input int mat_scale);
        return mat_scale * mat_scale + mat_scale;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_job_arbiter_if.sv
`default_nettype none
// ============================================================================
// mvm_job_arbiter_if : requester-side and engine-side buses of the arbiter
// Rev 1.0
// ============================================================================
interface mvm_job_arbiter_if #(
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int NUM_REQ      = 2
);
    import mvm_pkg::*;

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           resp_valid;
    logic [ID_W-1:0]                resp_id;
    logic [OUTPUT_WIDTH-1:0]        resp_data;
    logic                           resp_last;
    logic                           mvm_start;
    logic [INPUT_WIDTH-1:0]         mvm_data_in;
    logic                           mvm_done;
    logic [OUTPUT_WIDTH-1:0]        mvm_data_out;

    modport master (
        input  req_valid, req_data, mvm_done, mvm_data_out,
        output req_ready, resp_valid, resp_id, resp_data, resp_last,
               mvm_start, mvm_data_in
    );

    modport slave (
        output req_valid, req_data, mvm_done, mvm_data_out,
        input  req_ready, resp_valid, resp_id, resp_data, resp_last,
               mvm_start, mvm_data_in
    );

endinterface
`default_nettype wire

// File: rtl/mvm_job_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, scanning upward from last+1
// Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               found
);

    always_comb begin
        int k;
        k         = 0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            k = (int'(last_grant) + off) % NUM_REQ;
            if (!found && req[k]) begin
                grant_idx = ID_W'(k);
                found     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mvm_job_arbiter.sv
`default_nettype none
// ============================================================================
// mvm_job_arbiter : buffers one requester's MVM job, streams it into the
// shared engine and returns tagged results. Optional: MVM_JOB_ARB_STATS_EN.
// Rev 1.0
// ============================================================================
module mvm_job_arbiter
    import mvm_pkg::*;
#(
    parameter int MAT_SCALE    = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int NUM_REQ      = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mvm_job_arbiter_if.master bus,
    output logic              busy
`ifdef MVM_JOB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] job_count
`endif
);

    localparam int JOB_WORDS = job_words(MAT_SCALE);
    localparam int ID_W      = id_width(NUM_REQ);
    localparam int CNT_W     = $clog2(JOB_WORDS + 1);

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic [ID_W-1:0]         last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        wcnt_q, wcnt_d;
    logic [CNT_W-1:0]        rcnt_q, rcnt_d;
    logic [INPUT_WIDTH-1:0]  job_buf_q [JOB_WORDS];
    logic [INPUT_WIDTH-1:0]  job_buf_d [JOB_WORDS];
    logic [INPUT_WIDTH-1:0]  data_in_q, data_in_d;

    logic [ID_W-1:0]         arb_idx;
    logic                    arb_found;
    logic                    drain_done;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    resp_valid;
    logic [ID_W-1:0]         resp_id;
    logic [OUTPUT_WIDTH-1:0] resp_data;
    logic                    resp_last;
    logic                    mvm_start;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant_idx  (arb_idx),
        .found      (arb_found)
    );

    assign drain_done = (state_q == ST_DRAIN) && (rcnt_q == CNT_W'(MAT_SCALE - 1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        job_buf_d    = job_buf_q;
        data_in_d    = data_in_q;
        req_ready    = '0;
        resp_valid   = 1'b0;
        resp_id      = '0;
        resp_data    = '0;
        resp_last    = 1'b0;
        mvm_start    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    wcnt_d  = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                req_ready[grant_q] = 1'b1;
                if (bus.req_valid[grant_q]) begin
                    job_buf_d[wcnt_q] = bus.req_data[int'(grant_q)*INPUT_WIDTH +: INPUT_WIDTH];
                    wcnt_d = wcnt_q + CNT_W'(1);
                    if (wcnt_q == CNT_W'(JOB_WORDS - 1)) begin
                        wcnt_d  = '0;
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                // Preload word 0 so it is on the engine input the first FEED cycle
                mvm_start = 1'b1;
                data_in_d = job_buf_q[0];
                rcnt_d    = '0;
                state_d   = ST_FEED;
            end
            ST_FEED: begin
                if (rcnt_q == CNT_W'(JOB_WORDS - 1)) begin
                    data_in_d = '0;
                    rcnt_d    = '0;
                    state_d   = ST_WAIT;
                end else begin
                    data_in_d = job_buf_q[rcnt_q + CNT_W'(1)];
                    rcnt_d    = rcnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (bus.mvm_done) begin
                    rcnt_d  = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                resp_valid = 1'b1;
                resp_id    = grant_q;
                resp_data  = bus.mvm_data_out;
                rcnt_d     = rcnt_q + CNT_W'(1);
                if (drain_done) begin
                    resp_last    = 1'b1;
                    last_grant_d = grant_q;
                    rcnt_d       = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            data_in_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            data_in_q    <= data_in_d;
        end
    end

    // Job payload needs no reset: it is always fully rewritten before use
    always_ff @(posedge clk) begin
        job_buf_q <= job_buf_d;
    end

    assign bus.req_ready   = req_ready;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_id     = resp_id;
    assign bus.resp_data   = resp_data;
    assign bus.resp_last   = resp_last;
    assign bus.mvm_start   = mvm_start;
    assign bus.mvm_data_in = data_in_q;
    assign busy            = (state_q != ST_IDLE);

`ifdef MVM_JOB_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [15:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (drain_done && (grant_q == ID_W'(gi)) && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign job_count[gi*16 +: 16] = cnt_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mvm_job_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mvm_job_arbiter : directed bench with a behavioural MVM engine model
// Rev 1.0
// ============================================================================
module tb_mvm_job_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic spur_done;
`ifdef MVM_JOB_ARB_STATS_EN
    logic [31:0] job_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int drv_err  = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int rise_cyc  = 0;
    logic busy_d = 1'b0;

    int          q_id[$];
    logic [15:0] q_data[$];
    int          q_last[$];

    mvm_job_arbiter_if #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .NUM_REQ(2)) bus ();

    mvm_job_arbiter #(
        .MAT_SCALE(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16), .NUM_REQ(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
`ifdef MVM_JOB_ARB_STATS_EN
        ,
        .job_count (job_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural engine: capture 20 words after start, done 3 cycles later, y[i] at done+1+i
    int          e_phase = 0;
    int          e_cnt   = 0;
    logic        e_done  = 1'b0;
    logic [7:0]  e_buf [20];
    logic [15:0] e_y [4];

    always @(posedge clk) begin
        if (reset) begin
            e_phase <= 0;
            e_cnt   <= 0;
            e_done  <= 1'b0;
        end else begin
            e_done <= 1'b0;
            case (e_phase)
                0: if (bus.mvm_start) begin e_phase <= 1; e_cnt <= 0; end
                1: begin
                    e_buf[e_cnt] <= bus.mvm_data_in;
                    if (e_cnt == 19) begin e_phase <= 2; e_cnt <= 0; end
                    else e_cnt <= e_cnt + 1;
                end
                2: begin
                    if (e_cnt == 2) begin e_done <= 1'b1; e_phase <= 3; e_cnt <= 0; end
                    else e_cnt <= e_cnt + 1;
                end
                default: begin
                    if (e_cnt == 4) e_phase <= 0;
                    e_cnt <= e_cnt + 1;
                end
            endcase
        end
    end

    always_comb begin
        int s;
        s = 0;
        for (int r = 0; r < 4; r++) begin
            s = 0;
            for (int c = 0; c < 4; c++) s = s + $signed(e_buf[4*r+c]) * $signed(e_buf[16+c]);
            e_y[r] = 16'(s);
        end
    end

    assign bus.mvm_done     = e_done | spur_done;
    assign bus.mvm_data_out = (e_phase == 3 && e_cnt >= 1 && e_cnt <= 4) ? e_y[e_cnt-1] : 16'h5A5A;

    always @(negedge clk) begin
        if (bus.resp_valid) begin
            q_id.push_back(int'(bus.resp_id));
            q_data.push_back(bus.resp_data);
            q_last.push_back(int'(bus.resp_last));
        end
        if (bus.mvm_start) start_cyc <= cyc;
        if (busy && !busy_d) rise_cyc <= cyc;
        busy_d <= busy;
    end

    // Job word i of pattern 'kind': A row-major (i<16), then x
    function automatic logic [7:0] job_word(input int kind, input int i);
        int r, c;
        r = i / 4;
        c = i % 4;
        case (kind)
            0: return (i < 16) ? ((r == c) ? 8'd1 : 8'd0) : 8'(c + 1);
            1: return 8'h80;
            2: return (i < 16) ? ((r == c) ? 8'd2 : 8'd0) : 8'(c + 5);
            default: return (i < 16) ? 8'(i) : ((c == 0 || c == 3) ? 8'd1 : 8'd0);
        endcase
    endfunction

    function automatic logic [15:0] exp_y(input int kind, input int r);
        logic [63:0] t;
        case (kind)
            0: t = {16'd4, 16'd3, 16'd2, 16'd1};
            1: t = {16'd0, 16'd0, 16'd0, 16'd0};
            2: t = {16'd16, 16'd14, 16'd12, 16'd10};
            default: t = {16'd27, 16'd19, 16'd11, 16'd3};
        endcase
        return t[r*16 +: 16];
    endfunction

    task automatic send_job(input int id, input int kind, input int stall_at, input int stall_len);
        int t;
        for (int i = 0; i < 20; i++) begin
            if (i == stall_at) begin
                bus.req_valid[id] = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            bus.req_data[id*8 +: 8] = job_word(kind, i);
            bus.req_valid[id] = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.req_ready[id] && t < 2000);
            if (!bus.req_ready[id]) begin
                drv_err++;
                bus.req_valid[id] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp(input int n, output bit timed_out);
        int t;
        t = 0;
        while (q_data.size() < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        timed_out = (q_data.size() < n) || (drv_err != 0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (bus.req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); else n_pass++;
        n_checks++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); else n_pass++;
        n_checks++; if (bus.resp_id !== 1'b0) $display("FAIL reset_resp_id: got %b want 0", bus.resp_id); else n_pass++;
        n_checks++; if (bus.resp_data !== 16'd0) $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); else n_pass++;
        n_checks++; if (bus.resp_last !== 1'b0) $display("FAIL reset_resp_last: got %b want 0", bus.resp_last); else n_pass++;
        n_checks++; if (bus.mvm_start !== 1'b0) $display("FAIL reset_mvm_start: got %b want 0", bus.mvm_start); else n_pass++;
        n_checks++; if (bus.mvm_data_in !== 8'd0) $display("FAIL reset_mvm_data_in: got %h want 0", bus.mvm_data_in); else n_pass++;
    endtask

    task automatic test_single;
        int base;
        bit to;
        base = q_data.size();
        send_job(0, 0, -1, 0);
        wait_resp(base + 4, to);
        n_checks++; if (to) $display("FAIL single_timeout: got %0d words want 4", q_data.size() - base); else n_pass++;
        n_checks++; if (start_cyc - rise_cyc !== 20) $display("FAIL single_start_latency: got %0d want 20", start_cyc - rise_cyc); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q_data[base+i] !== exp_y(0, i)) $display("FAIL single_data[%0d]: got %0d want %0d", i, q_data[base+i], exp_y(0, i));
            else n_pass++;
            n_checks++;
            if (q_id[base+i] !== 0 || q_last[base+i] !== int'(i == 3))
                $display("FAIL single_tag[%0d]: got id=%0d last=%0d want id=0 last=%0d", i, q_id[base+i], q_last[base+i], int'(i == 3));
            else n_pass++;
        end
    endtask

    task automatic test_two_req;
        int base;
        bit to;
        int ids [3];
        int kinds [3];
        ids   = '{0, 1, 0};
        kinds = '{0, 3, 2};
        do_reset();
        base = q_data.size();
        fork
            begin send_job(0, 0, -1, 0); send_job(0, 2, -1, 0); end
            send_job(1, 3, -1, 0);
        join
        wait_resp(base + 12, to);
        n_checks++; if (to) $display("FAIL two_req_timeout: got %0d words want 12", q_data.size() - base); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_id[base+4*j+i] !== ids[j] || q_data[base+4*j+i] !== exp_y(kinds[j], i))
                    $display("FAIL two_req_job%0d_word%0d: got id=%0d data=%0d want id=%0d data=%0d", j, i,
                             q_id[base+4*j+i], q_data[base+4*j+i], ids[j], exp_y(kinds[j], i));
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall;
        int base;
        bit to;
        base = q_data.size();
        send_job(1, 1, 10, 3);
        wait_resp(base + 4, to);
        n_checks++; if (to) $display("FAIL stall_timeout: got %0d words want 4", q_data.size() - base); else n_pass++;
        n_checks++; if (start_cyc - rise_cyc !== 23) $display("FAIL stall_start_latency: got %0d want 23", start_cyc - rise_cyc); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q_id[base+i] !== 1 || q_data[base+i] !== 16'd0 || q_last[base+i] !== int'(i == 3))
                $display("FAIL stall_word[%0d]: got id=%0d data=%0d last=%0d want id=1 data=0 last=%0d", i,
                         q_id[base+i], q_data[base+i], q_last[base+i], int'(i == 3));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int base;
        bit to;
        send_job(0, 0, -1, 0);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL midreset_busy_before: got %b want 1", busy); else n_pass++;
        base = q_data.size();
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (bus.mvm_data_in !== 8'd0) $display("FAIL midreset_data_in: got %h want 0", bus.mvm_data_in); else n_pass++;
        n_checks++; if ({bus.req_ready, bus.resp_valid, bus.resp_last, bus.mvm_start} !== 5'd0)
            $display("FAIL midreset_ctrl: got %b want 00000", {bus.req_ready, bus.resp_valid, bus.resp_last, bus.mvm_start}); else n_pass++;
        n_checks++; if ({bus.resp_id, bus.resp_data} !== 17'd0)
            $display("FAIL midreset_resp: got id=%0d data=%0d want 0 0", bus.resp_id, bus.resp_data); else n_pass++;
        reset = 1'b0;
        send_job(0, 3, -1, 0);
        wait_resp(base + 4, to);
        n_checks++; if (to || q_data.size() !== base + 4) $display("FAIL midreset_count: got %0d words want 4", q_data.size() - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q_id[base+i] !== 0 || q_data[base+i] !== exp_y(3, i))
                $display("FAIL midreset_word[%0d]: got id=%0d data=%0d want id=0 data=%0d", i, q_id[base+i], q_data[base+i], exp_y(3, i));
            else n_pass++;
        end
    endtask

    task automatic test_spurious_done;
        int base;
        bit to;
        base = q_data.size();
        fork
            send_job(1, 2, -1, 0);
            begin
                repeat (5) @(posedge clk);
                #1;
                spur_done = 1'b1;
                @(posedge clk);
                #1;
                spur_done = 1'b0;
                @(negedge clk);
                n_checks++; if (bus.resp_valid !== 1'b0 || q_data.size() !== base)
                    $display("FAIL spurious_resp: got resp_valid=%b words=%0d want 0 0", bus.resp_valid, q_data.size() - base); else n_pass++;
                n_checks++; if (bus.req_ready !== 2'b10) $display("FAIL spurious_still_loading: got %b want 10", bus.req_ready); else n_pass++;
            end
        join
        wait_resp(base + 4, to);
        n_checks++; if (to) $display("FAIL spurious_timeout: got %0d words want 4", q_data.size() - base); else n_pass++;
        n_checks++; if (start_cyc - rise_cyc !== 20) $display("FAIL spurious_start_latency: got %0d want 20", start_cyc - rise_cyc); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q_id[base+i] !== 1 || q_data[base+i] !== exp_y(2, i))
                $display("FAIL spurious_word[%0d]: got id=%0d data=%0d want id=1 data=%0d", i, q_id[base+i], q_data[base+i], exp_y(2, i));
            else n_pass++;
        end
    endtask

`ifdef MVM_JOB_ARB_STATS_EN
    task automatic test_stats;
        int base;
        bit to;
        do_reset();
        base = q_data.size();
        for (int j = 0; j < 3; j++) send_job(1, j, -1, 0);
        wait_resp(base + 12, to);
        n_checks++; if (to) $display("FAIL stats_timeout: got %0d words want 12", q_data.size() - base); else n_pass++;
        n_checks++; if (job_count[31:16] !== 16'd3) $display("FAIL stats_req1: got %0d want 3", job_count[31:16]); else n_pass++;
        n_checks++; if (job_count[15:0] !== 16'd0) $display("FAIL stats_req0: got %0d want 0", job_count[15:0]); else n_pass++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion want completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset         = 1'b1;
        spur_done     = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_two_req();
        test_stall();
        test_reset_mid();
        test_spurious_done();
`ifdef MVM_JOB_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
